// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller: FSM state encoding
// as seen on the STATE output.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOAD = 2'd3
  } state_e;

endpackage

// File: rtl/run_rate_div.sv
// Free-run rate divider: while enabled, counts 0..DIV-1 and flags the
// terminal count. clr wins over en and forces the count back to zero.
module run_rate_div #(
  parameter int unsigned DIV = 50000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Halt / single-step / free-run sequencer producing the MIPS core clock-enable.
// Define CPU_RUN_CTRL_BRKPT_EN to enable the PC breakpoint that stops free-run.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV  = 50000000,
  parameter int unsigned CNTW = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               STEP_P,
  input  logic               RUN_P,
  input  logic               WE,
  input  logic [31:0]        PC,
  input  logic [31:0]        BRK_ADDR,
  input  logic               BRK_VALID,
  output logic               CPU_EN,
  output logic [STATE_W-1:0] STATE,
  output logic               BRK_HIT,
  output logic [CNTW-1:0]    INSTR_CNT
);

  state_e            state_q, state_d;
  logic              cpu_en_q, cpu_en_d;
  logic              brk_hit_q, brk_hit_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              load_entry;
  logic              div_clr, div_en, div_tick;
  logic              brk_match;

`ifdef CPU_RUN_CTRL_BRKPT_EN
  assign brk_match = BRK_VALID && (PC == BRK_ADDR);
`else
  logic unused_brk;
  assign unused_brk = ^{PC, BRK_ADDR, BRK_VALID};
  assign brk_match  = 1'b0;
`endif

  // Divider only runs in RUN; it sits at zero everywhere else so RUN entry starts fresh.
  assign div_en  = (state_q == ST_RUN);
  assign div_clr = (state_q != ST_RUN);

  run_rate_div #(
    .DIV (DIV)
  ) u_div (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (div_clr),
    .en   (div_en),
    .tick (div_tick)
  );

  always_comb begin
    state_d    = state_q;
    cpu_en_d   = 1'b0;
    brk_hit_d  = brk_hit_q;
    cnt_d      = cpu_en_q ? cnt_q + CNTW'(1) : cnt_q;
    load_entry = 1'b0;

    case (state_q)
      ST_HALT: begin
        if (WE) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end else if (RUN_P) begin
          state_d   = ST_RUN;
          brk_hit_d = 1'b0;
        end else if (STEP_P) begin
          state_d   = ST_STEP;
          brk_hit_d = 1'b0;
        end
      end
      ST_STEP: begin
        if (WE) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end else begin
          cpu_en_d = 1'b1;
          state_d  = ST_HALT;
        end
      end
      ST_RUN: begin
        if (WE) begin
          state_d    = ST_LOAD;
          load_entry = 1'b1;
        end else if (RUN_P) begin
          state_d = ST_HALT;
        end else if (div_tick) begin
          // PC still names the instruction this tick would release.
          if (brk_match) begin
            state_d   = ST_HALT;
            brk_hit_d = 1'b1;
          end else begin
            cpu_en_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (!WE) begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (load_entry) begin
      cnt_d     = '0;
      brk_hit_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_HALT;
      cpu_en_q  <= 1'b0;
      brk_hit_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      brk_hit_q <= brk_hit_d;
      cnt_q     <= cnt_d;
    end
  end

  assign CPU_EN    = cpu_en_q;
  assign STATE     = state_q;
  assign BRK_HIT   = brk_hit_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: vector table, directed corner sequences
// and a randomized run against a cycle-level behavioural model.
module tb_cpu_run_ctrl;

  localparam int DIV_T = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        STEP_P = 1'b0, RUN_P = 1'b0, WE = 1'b0, BRK_VALID = 1'b0;
  logic [31:0] PC = '0, BRK_ADDR = '0;
  logic        CPU_EN, BRK_HIT;
  logic [1:0]  STATE;
  logic [31:0] INSTR_CNT;
  logic        cpu_en1, brk_hit1;
  logic [1:0]  state1;
  logic [31:0] instr_cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0..3, cycles spent in RUN, pending enable, sticky hit, count.
  int          m_state, m_age;
  bit          m_en, m_brk;
  logic [31:0] m_cnt;

  typedef struct {
    bit run_p;
    bit step_p;
    bit we;
    int exp_state;
    bit exp_en;
    int exp_cnt;
  } vec_t;

  vec_t vecs[17];

  cpu_run_ctrl #(.DIV(DIV_T), .CNTW(32)) u_dut (
    .CLK(CLK), .RST(RST), .STEP_P(STEP_P), .RUN_P(RUN_P), .WE(WE),
    .PC(PC), .BRK_ADDR(BRK_ADDR), .BRK_VALID(BRK_VALID),
    .CPU_EN(CPU_EN), .STATE(STATE), .BRK_HIT(BRK_HIT), .INSTR_CNT(INSTR_CNT)
  );

  cpu_run_ctrl #(.DIV(1), .CNTW(32)) u_dut1 (
    .CLK(CLK), .RST(RST), .STEP_P(STEP_P), .RUN_P(RUN_P), .WE(WE),
    .PC(PC), .BRK_ADDR(BRK_ADDR), .BRK_VALID(BRK_VALID),
    .CPU_EN(cpu_en1), .STATE(state1), .BRK_HIT(brk_hit1), .INSTR_CNT(instr_cnt1)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_age = 0; m_en = 0; m_brk = 0; m_cnt = '0;
  endtask

  task automatic model_step();
    int ns;
    bit nen;
    bit tick;
    bit brk_on;
`ifdef CPU_RUN_CTRL_BRKPT_EN
    brk_on = 1'b1;
`else
    brk_on = 1'b0;
`endif
    ns  = m_state;
    nen = 1'b0;
    if (m_en) m_cnt = m_cnt + 32'd1;
    case (m_state)
      0: begin
        if (WE) ns = 3;
        else if (RUN_P) begin ns = 2; m_age = 0; m_brk = 0; end
        else if (STEP_P) begin ns = 1; m_brk = 0; end
      end
      1: begin
        if (WE) ns = 3;
        else begin nen = 1'b1; ns = 0; end
      end
      2: begin
        if (WE) ns = 3;
        else if (RUN_P) ns = 0;
        else begin
          tick  = (m_age % DIV_T) == DIV_T - 1;
          m_age = m_age + 1;
          if (tick && brk_on && BRK_VALID && (PC == BRK_ADDR)) begin
            ns = 0; m_brk = 1'b1;
          end else if (tick) begin
            nen = 1'b1;
          end
        end
      end
      default: begin
        if (!WE) ns = 0;
      end
    endcase
    if (ns == 3 && m_state != 3) begin
      m_cnt = '0;
      m_brk = 1'b0;
    end
    m_state = ns;
    m_en    = nen;
  endtask

  // One clock cycle; the core model advances PC after each enabled cycle and restarts on load.
  task automatic applyStimulus(input bit run_p, input bit step_p, input bit we);
    bit en_prev;
    RUN_P   = run_p;
    STEP_P  = step_p;
    WE      = we;
    en_prev = CPU_EN;
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    if (we) PC = '0;
    else if (en_prev) PC = PC + 32'd4;
    RUN_P  = 1'b0;
    STEP_P = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; RUN_P = 1'b0; STEP_P = 1'b0; WE = 1'b0; PC = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int en_count;
    int we_left;
    bit halted;

    vecs[0]  = '{1, 1, 0, 2, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 1};
    vecs[5]  = '{1, 0, 1, 3, 0, 0};
    vecs[6]  = '{0, 0, 1, 3, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 0, 0};
    vecs[9]  = '{0, 0, 1, 3, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 2, 0, 0};
    vecs[12] = '{0, 1, 0, 2, 0, 0};
    vecs[13] = '{0, 0, 0, 2, 0, 0};
    vecs[14] = '{0, 0, 0, 2, 0, 0};
    vecs[15] = '{0, 0, 0, 2, 1, 0};
    vecs[16] = '{1, 0, 0, 0, 0, 1};

    $display("[TB] reset and vector table");
    do_reset();
    checkOutput("rst_state", 32'(STATE), 32'd0);
    checkOutput("rst_en", 32'(CPU_EN), 32'd0);
    checkOutput("rst_brk", 32'(BRK_HIT), 32'd0);
    checkOutput("rst_cnt", INSTR_CNT, 32'd0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].run_p, vecs[i].step_p, vecs[i].we);
      checkOutput($sformatf("vec%0d_state", i), 32'(STATE), 32'(vecs[i].exp_state));
      checkOutput($sformatf("vec%0d_en", i), 32'(CPU_EN), 32'(vecs[i].exp_en));
      checkOutput($sformatf("vec%0d_cnt", i), INSTR_CNT, 32'(vecs[i].exp_cnt));
    end

    $display("[TB] free-run rate, DIV=4 and DIV=1");
    do_reset();
    applyStimulus(1, 0, 0);
    for (int k = 1; k <= 13; k++) begin
      checkOutput($sformatf("runA_en_c%0d", k), 32'(CPU_EN), 32'(k == 5 || k == 9 || k == 13));
      checkOutput($sformatf("runA_div1_en_c%0d", k), 32'(cpu_en1), 32'(k >= 2));
      applyStimulus(0, 0, 0);
    end
    checkOutput("runA_cnt", INSTR_CNT, 32'd3);
    checkOutput("runA_div1_cnt", instr_cnt1, 32'd12);

    $display("[TB] two single steps");
    do_reset();
    en_count = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, (i == 0 || i == 10), 0);
      if (CPU_EN) en_count++;
      if (i == 1 || i == 11) checkOutput($sformatf("step_state_c%0d", i + 1), 32'(STATE), 32'd0);
    end
    checkOutput("step_pulses", 32'(en_count), 32'd2);
    checkOutput("step_cnt", INSTR_CNT, 32'd2);

    $display("[TB] load freezes run");
    do_reset();
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput("load_state", 32'(STATE), 32'd3);
      checkOutput("load_en", 32'(CPU_EN), 32'd0);
      checkOutput("load_cnt", INSTR_CNT, 32'd0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("load_exit_state", 32'(STATE), 32'd0);

    $display("[TB] breakpoint");
    do_reset();
    BRK_ADDR  = 32'h10;
    BRK_VALID = 1'b1;
    applyStimulus(1, 0, 0);
    en_count = 0;
    halted   = 1'b0;
    for (int i = 0; i < 60 && !halted; i++) begin
      applyStimulus(0, 0, 0);
      if (CPU_EN) en_count++;
      if (STATE == 2'd0) halted = 1'b1;
    end
`ifdef CPU_RUN_CTRL_BRKPT_EN
    checkOutput("brk_halted", 32'(halted), 32'd1);
    checkOutput("brk_pulses", 32'(en_count), 32'd4);
    checkOutput("brk_pc", PC, 32'h10);
    checkOutput("brk_hit", 32'(BRK_HIT), 32'd1);
    applyStimulus(0, 1, 0);
    checkOutput("brk_step_clear", 32'(BRK_HIT), 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("brk_step_en", 32'(CPU_EN), 32'd1);
`else
    checkOutput("nobrk_still_run", 32'(STATE), 32'd2);
    checkOutput("nobrk_hit", 32'(BRK_HIT), 32'd0);
    applyStimulus(1, 0, 0);
`endif
    BRK_VALID = 1'b0;

    $display("[TB] async reset mid-run");
    do_reset();
    applyStimulus(1, 0, 0);
    for (int k = 1; k < 11; k++) applyStimulus(0, 0, 0);
    checkOutput("arst_pre_cnt", INSTR_CNT, 32'd2);
    RST = 1'b0;
    #1;
    checkOutput("arst_en", 32'(CPU_EN), 32'd0);
    checkOutput("arst_state", 32'(STATE), 32'd0);
    checkOutput("arst_cnt", INSTR_CNT, 32'd0);
    checkOutput("arst_brk", 32'(BRK_HIT), 32'd0);
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput("arst_post_en", 32'(CPU_EN), 32'd0);
      checkOutput("arst_post_state", 32'(STATE), 32'd0);
    end

    $display("[TB] randomized run against model");
    do_reset();
    we_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        BRK_VALID = 1'($urandom_range(0, 1));
        BRK_ADDR  = 32'($urandom_range(0, 12)) * 32'd4;
      end
      if (we_left > 0) we_left--;
      else if ($urandom_range(0, 40) == 0) we_left = int'($urandom_range(1, 6));
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0, we_left > 0);
      checkOutput("rnd_state", 32'(STATE), 32'(m_state));
      checkOutput("rnd_en", 32'(CPU_EN), 32'(m_en));
      checkOutput("rnd_brk", 32'(BRK_HIT), 32'(m_brk));
      checkOutput("rnd_cnt", INSTR_CNT, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
